bit_index_serializer: RTL

Serializing companion to the bit population counter. It accepts one `WIDTH`-bit word and emits the index of each set bit, one index per beat, in ascending order, over a valid/ready stream. Each beat carries a running ordinal, so on the final beat the ordinal equals the word's population count. It sits downstream of the counter path wherever consumers need the positions of the set bits, not just how many there are.

---
 rtl/bit_index_serializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bit_index_serializer.sv
// Serializes one WIDTH-bit word into a stream of set-bit indices, lowest first,
// each beat tagged with a 1-based ordinal; an all-zero word yields one marker beat.
module bit_index_serializer #(
    parameter  int WIDTH = 63,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [CNT_W-1:0] idx_num_o,
    output logic             idx_none_o,
    output logic             idx_last_o,
    output logic             idx_val_o,
    input  logic             idx_ready_i,
    output logic             dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never drops and its payload never changes until then.

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mask;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_num;
    logic               r_none;
    logic               r_last;
    logic               r_val;

    logic [WIDTH-1:0]   w_src;
    logic [WIDTH-1:0]   w_rest;
    logic [IDX_W-1:0]   w_low_idx;
    logic               w_src_zero;
    logic               w_rest_zero;

    // The same encoder serves the incoming word and the residual mask.
    assign w_src       = (r_state == ST_IDLE) ? data_i : r_mask;
    assign w_rest      = w_src & (w_src - WIDTH'(1));
    assign w_src_zero  = (w_src == '0);
    assign w_rest_zero = (w_rest == '0);

    always_comb begin
        w_low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_src[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_idx   <= '0;
            r_num   <= '0;
            r_none  <= 1'b0;
            r_last  <= 1'b0;
            r_val   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (data_val_i) begin
                        r_state <= ST_EMIT;
                        r_val   <= 1'b1;
                        if (w_src_zero) begin
                            r_idx  <= '0;
                            r_num  <= '0;
                            r_none <= 1'b1;
                            r_last <= 1'b1;
                            r_mask <= '0;
                        end else begin
                            r_idx  <= w_low_idx;
                            r_num  <= CNT_W'(1);
                            r_none <= 1'b0;
                            r_last <= w_rest_zero;
                            r_mask <= w_rest;
                        end
                    end
                end
                ST_EMIT: begin
                    if (idx_ready_i) begin
                        if (r_last) begin
                            // idx/num are left as-is; they are meaningless once valid drops.
                            r_state <= ST_IDLE;
                            r_val   <= 1'b0;
                            r_none  <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_idx  <= w_low_idx;
                            r_num  <= r_num + CNT_W'(1);
                            r_last <= w_rest_zero;
                            r_mask <= w_rest;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_val   <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready_o = !r_val;
    assign idx_o        = r_idx;
    assign idx_num_o    = r_num;
    assign idx_none_o   = r_none;
    assign idx_last_o   = r_last;
    assign idx_val_o    = r_val;
    assign dbg_state_o  = (r_state == ST_EMIT);

endmodule
